// File: rtl/fpu_pkg.sv
// FPU shared types and widths.
// Used by the mantissa datapath blocks.
package fpu_pkg;

  localparam int SP_MANT = 24;
  localparam int DP_MANT = 53;

  // Extra quotient bits: one for the
  // normalize shift, plus guard and round.
  localparam int GR_BITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int q_width(
    input int dw
  );
    return dw + GR_BITS;
  endfunction

endpackage

// File: rtl/mant_div_seq_if.sv
// Operand/result handshake bundle
// for the sequential mantissa divider.
interface mant_div_seq_if
  import fpu_pkg::*;
#(
  parameter int DWIDTH = SP_MANT,
  parameter int QWIDTH = q_width(DWIDTH)
);

  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] a;
  logic [DWIDTH-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [QWIDTH-1:0] q;
  logic              sticky;
  logic              dz;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  q,
    input  sticky,
    input  dz
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output q,
    output sticky,
    output dz
  );

endinterface

// File: rtl/cla_adder.sv
// Carry-lookahead adder built from
// generate/propagate terms.
module cla_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Carry chain from generate/propagate.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/div_step.sv
// One restoring-division step:
// trial subtract, select, shift left.
module div_step #(
  parameter int DWIDTH = 24
) (
  input  logic [DWIDTH:0]   rem,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH:0]   next_rem,
  output logic              qbit
);

  logic [DWIDTH:0] diff;
  logic [DWIDTH:0] sel;
  logic            ge;

  // rem + ~b + 1; carry out set means
  // the difference is non-negative.
  cla_adder #(
    .W (DWIDTH+1)
  ) u_sub (
    .x    (rem),
    .y    (~{1'b0, b}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (ge)
  );

  assign qbit     = ge;
  assign sel      = ge ? diff : rem;
  // sel < b, so the shift never drops a one.
  assign next_rem = sel << 1;

endmodule

// File: rtl/mant_div_seq.sv
// Iterative restoring mantissa divider,
// one quotient bit per clock.
module mant_div_seq
  import fpu_pkg::*;
#(
  parameter int DWIDTH = SP_MANT,
  parameter int QWIDTH = q_width(DWIDTH),
  parameter int CWIDTH = $clog2(QWIDTH+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  mant_div_seq_if.slave bus
);

  div_state_e        state;
  logic [CWIDTH-1:0] cnt;
  logic [DWIDTH:0]   rem;
  logic [DWIDTH:0]   next_rem;
  logic [DWIDTH-1:0] b_q;
  logic [QWIDTH-1:0] q_r;
  logic              sticky_r;
  logic              dz_r;
  logic              qbit;
  logic              accept;
  logic              b_zero;

  assign accept = bus.in_valid
                & (state == IDLE);
  assign b_zero = (bus.b == '0);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.q         = q_r;
  assign bus.sticky    = sticky_r;
  assign bus.dz        = dz_r;

  div_step #(
    .DWIDTH (DWIDTH)
  ) u_step (
    .rem      (rem),
    .b        (b_q),
    .next_rem (next_rem),
    .qbit     (qbit)
  );

  // FSM, iteration counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      b_q      <= '0;
      q_r      <= '0;
      sticky_r <= 1'b0;
      dz_r     <= 1'b0;
    end else if (flush) begin
      if (state != IDLE) begin
        state    <= IDLE;
        cnt      <= '0;
        rem      <= '0;
        q_r      <= '0;
        sticky_r <= 1'b0;
        dz_r     <= 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (b_zero) begin
              q_r      <= '1;
              sticky_r <= 1'b0;
              dz_r     <= 1'b1;
              state    <= DONE;
            end else begin
              rem      <= {1'b0, bus.a};
              b_q      <= bus.b;
              q_r      <= '0;
              cnt      <= CWIDTH'(QWIDTH);
              sticky_r <= 1'b0;
              dz_r     <= 1'b0;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= next_rem;
          q_r <= {q_r[QWIDTH-2:0], qbit};
          cnt <= cnt - CWIDTH'(1);
          if (cnt == CWIDTH'(1)) begin
            sticky_r <= |next_rem;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divisor must be normalized unless zero.
  a_b_norm: assert property (
    @(posedge clk) disable iff (!rst_n)
    (accept && !flush && !b_zero)
      |-> bus.b[DWIDTH-1]
  ) else $error("divisor not normalized");

endmodule

// File: tb/tb_mant_div_seq.sv
// Scoreboard bench for mant_div_seq.
// Expected results come from an integer model.
module tb_mant_div_seq;
  import fpu_pkg::*;

  localparam int DW = 24;
  localparam int QW = 27;

  typedef struct packed {
    logic [QW-1:0] q;
    logic          sticky;
    logic          dz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mant_div_seq_if #(
    .DWIDTH (DW),
    .QWIDTH (QW)
  ) bus ();

  mant_div_seq #(
    .DWIDTH (DW),
    .QWIDTH (QW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    exp_t        e;
    logic [63:0] num;
    logic [63:0] den;
    if (b == '0) begin
      e.q      = '1;
      e.sticky = 1'b0;
      e.dz     = 1'b1;
    end else begin
      num      = {40'd0, a} << (QW-1);
      den      = {40'd0, b};
      e.q      = QW'(num / den);
      e.sticky = (num % den) != 64'd0;
      e.dz     = 1'b0;
    end
    return e;
  endfunction

  task automatic send(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got %b want 1",
               bus.in_ready);
    end
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(
    input string name,
    input int    lat,
    input bit    release_out
  );
    int   n = 1;
    exp_t e;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout out_valid %b want 1",
               name, bus.out_valid);
      sb.delete();
      return;
    end
    if (lat > 0) begin
      checks++;
      if (n !== lat) begin
        errors++;
        $display("FAIL %s latency got %0d want %0d",
                 name, n, lat);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected result q %h",
               name, bus.q);
      return;
    end
    e = sb.pop_front();
    if (bus.q !== e.q) begin
      errors++;
      $display("FAIL %s q got %h want %h",
               name, bus.q, e.q);
    end
    checks++;
    if (bus.sticky !== e.sticky) begin
      errors++;
      $display("FAIL %s sticky got %b want %b",
               name, bus.sticky, e.sticky);
    end
    checks++;
    if (bus.dz !== e.dz) begin
      errors++;
      $display("FAIL %s dz got %b want %b",
               name, bus.dz, e.dz);
    end
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 ||
          bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s release rdy/vld %b%b want 10",
                 name, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 ||
        bus.q !== '0 ||
        bus.sticky !== 1'b0 ||
        bus.dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_out vld %b q %h s %b dz %b want 0",
               bus.out_valid, bus.q, bus.sticky, bus.dz);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1",
               bus.in_ready);
    end
  endtask

  task automatic test_basic();
    send(24'h800000, 24'h800000);
    collect("one", 28, 1'b1);
    send(24'h800000, 24'hC00000);
    collect("two_thirds", 28, 1'b1);
    send(24'hFFFFFF, 24'h800000);
    collect("max_a", 28, 1'b1);
    send(24'hC00000, 24'h800000);
    collect("one_half", 28, 1'b1);
    send(24'h400000, 24'hFFFFFF);
    collect("denorm_a", 28, 1'b1);
  endtask

  task automatic test_div_zero();
    send(24'h900000, 24'h000000);
    collect("div_zero", 1, 1'b1);
  endtask

  task automatic test_random();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    for (int i = 0; i < 6; i++) begin
      a = DW'($urandom);
      b = 24'h800000 | DW'($urandom);
      send(a, b);
      collect("random", 28, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e = model(24'h800000, 24'hC00000);
    send(24'h800000, 24'hC00000);
    collect("bp_first", 28, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a        = 24'h123456;
      bus.b        = 24'h000000;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold vld/rdy %b%b want 10",
                 bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.q !== e.q ||
          bus.sticky !== e.sticky ||
          bus.dz !== e.dz) begin
        errors++;
        $display("FAIL bp_stable q %h s %b dz %b want %h %b %b",
                 bus.q, bus.sticky, bus.dz,
                 e.q, e.sticky, e.dz);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 ||
        bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rdy/vld %b%b want 10",
               bus.in_ready, bus.out_valid);
    end
    send(24'hFFFFFF, 24'h800000);
    collect("bp_second", 28, 1'b1);
  endtask

  task automatic check_quiet(input string name);
    int seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s stray out_valid cycles %0d want 0",
               name, seen);
    end
  endtask

  task automatic test_reset_mid();
    send(24'hFFFFFF, 24'h800000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.q !== '0) begin
      errors++;
      $display("FAIL rst_mid vld %b q %h want 0 0",
               bus.out_valid, bus.q);
    end
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready got %b want 1",
               bus.in_ready);
    end
    check_quiet("rst_mid");
    send(24'h800000, 24'h800000);
    collect("after_rst", 28, 1'b1);
  endtask

  task automatic test_flush_mid();
    send(24'hFFFFFF, 24'h800000);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state vld/rdy %b%b want 01",
               bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.q !== '0 ||
        bus.sticky !== 1'b0 ||
        bus.dz !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear q %h s %b dz %b want 0",
               bus.q, bus.sticky, bus.dz);
    end
    sb.delete();
    check_quiet("flush");
    send(24'h800000, 24'h800000);
    collect("after_flush", 28, 1'b1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_flush_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
